uart_rx_cfg: RTL and testbench

Parametrised UART receiver and next-generation replacement for the fixed 8N1 receiver. Supports configurable data width, optional odd/even parity, and one or two stop bits. Reports parity and framing errors, rejects start-bit glitches, and recovers cleanly from break conditions. Sits between the board RX pin and the byte consumer; one clock domain, asynchronous serial input.

---
 rtl/uart_rx_cfg.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2
// stop bits, start-bit glitch rejection and break (held-low line) recovery.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a falling edge
  // S_START  | timing to the start-bit midpoint, reject glitches
  // S_DATA   | sampling DATA_BITS data bits, LSB first
  // S_PARITY | sampling the parity bit
  // S_STOP   | sampling STOP_BITS stop bits, DV on the last one
  // S_BREAK  | frame error seen, waiting for the line to return high

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_MID       = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          PAR_ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 line;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frm_err;
  logic                 stop_bad;
  logic                 par_bad;

  // Error state including the sample being taken this cycle.
  assign stop_bad = frm_err | ~line;
  assign par_bad  = line != (^shreg ^ PAR_ODD);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta      <= 1'b1;
      line         <= 1'b1;
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      par_err      <= 1'b0;
      frm_err      <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      rx_meta      <= i_Rx_Serial;
      line         <= rx_meta;
      o_Rx_DV      <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Busy       <= 1'b1;

      case (state)
        S_IDLE: begin
          cnt    <= '0;
          idx    <= '0;
          o_Busy <= ~line;
          if (!line) begin
            par_err <= 1'b0;
            frm_err <= 1'b0;
            state   <= S_START;
          end
        end

        S_START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            idx <= '0;
            if (!line) begin
              state <= S_DATA;
            end else begin
              state  <= S_IDLE;
              o_Busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {line, shreg[DATA_BITS-1:1]};
            if (idx == IDX_DATA_LAST) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            idx     <= '0;
            par_err <= par_bad;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            frm_err <= stop_bad;
            if (idx == IDX_STOP_LAST) begin
              idx          <= '0;
              o_Rx_DV      <= 1'b1;
              o_Rx_Byte    <= shreg;
              o_Parity_Err <= par_err;
              o_Frame_Err  <= stop_bad;
              // Returning at the midpoint leaves half a bit to catch a
              // back-to-back start edge.
              state        <= stop_bad ? S_BREAK : S_IDLE;
              o_Busy       <= stop_bad;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BREAK: begin
          cnt <= '0;
          idx <= '0;
          if (line) begin
            state  <= S_IDLE;
            o_Busy <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          idx    <= '0;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) fed
// from a frame generator and checked against a frame-level reference model.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx = 3'b111;

  always #5 clk = ~clk;

  logic       dv0, dv1, dv2;
  logic [7:0] byte0, byte1;
  logic [6:0] byte2;
  logic       pe0, pe1, pe2, fe0, fe1, fe2, busy0, busy1, busy2;

  uart_rx_cfg #(.CLKS_PER_BIT(87), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv0), .o_Rx_Byte(byte0),
    .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Busy(busy0));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv1), .o_Rx_Byte(byte1),
    .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Busy(busy1));
  uart_rx_cfg #(.CLKS_PER_BIT(13), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv2), .o_Rx_Byte(byte2),
    .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Busy(busy2));

  int tests = 0;
  int fails = 0;

  // Frame monitor: counts DV pulses and keeps the last delivered frame.
  int         dv_cnt[3];
  logic [8:0] last_byte[3];
  logic       last_pe[3];
  logic       last_fe[3];
  int         low_run = 0;
  int         last_gap = 0;
  int         stray = 0;

  always @(negedge clk) begin
    if (dv0) begin
      dv_cnt[0]++; last_byte[0] = {1'b0, byte0}; last_pe[0] = pe0; last_fe[0] = fe0;
      last_gap = low_run; low_run = 0;
    end else if (!busy0) begin
      low_run++;
    end
    if (dv1) begin
      dv_cnt[1]++; last_byte[1] = {1'b0, byte1}; last_pe[1] = pe1; last_fe[1] = fe1;
    end
    if (dv2) begin
      dv_cnt[2]++; last_byte[2] = {2'b0, byte2}; last_pe[2] = pe2; last_fe[2] = fe2;
    end
    if ((pe0 | fe0) & !dv0) stray++;
    if ((pe1 | fe1) & !dv1) stray++;
    if ((pe2 | fe2) & !dv2) stray++;
  end

  function automatic int cpb_of(input int k);
    return (k == 0) ? 87 : (k == 1) ? 16 : 13;
  endfunction
  function automatic int nbits_of(input int k);
    return (k == 2) ? 7 : 8;
  endfunction
  function automatic int pmode_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 1;
  endfunction
  function automatic int nstop_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  // Parity bit a correct transmitter would send: even makes the ones count even.
  function automatic logic ref_par(input logic [8:0] d, input int nb, input int pm);
    logic p;
    p = 1'b0;
    for (int i = 0; i < nb; i++) p ^= d[i];
    return (pm == 1) ? ~p : p;
  endfunction

  task automatic drive_bit(input int k, input logic v, input int c);
    @(negedge clk);
    rx[k] = v;
    repeat (c - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [8:0] data, input logic par_bit,
                            input logic [1:0] stops, input int gap_bits);
    int c;
    c = cpb_of(k);
    drive_bit(k, 1'b0, c);
    for (int i = 0; i < nbits_of(k); i++) drive_bit(k, data[i], c);
    if (pmode_of(k) != 0) drive_bit(k, par_bit, c);
    for (int i = 0; i < nstop_of(k); i++) drive_bit(k, stops[i], c);
    for (int i = 0; i < gap_bits; i++) drive_bit(k, 1'b1, c);
  endtask

  task automatic test_reset;
    logic [31:0] got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    got = {dv0, byte0, pe0, fe0, busy0, dv1, byte1, pe1, fe1, busy1};
    tests++;
    if (got !== 32'h0) begin
      fails++; $display("FAIL reset_outs_01 got=%h exp=0", got);
    end
    got = {18'h0, dv2, byte2, pe2, fe2, busy2};
    tests++;
    if (got !== 32'h0) begin
      fails++; $display("FAIL reset_outs_2 got=%h exp=0", got);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if ({busy0, busy1, busy2} !== 3'b000) begin
      fails++; $display("FAIL reset_idle_busy got=%b exp=000", {busy0, busy1, busy2});
    end
    tests++;
    if (dv_cnt[0] + dv_cnt[1] + dv_cnt[2] != 0) begin
      fails++; $display("FAIL reset_no_dv got=%0d exp=0", dv_cnt[0] + dv_cnt[1] + dv_cnt[2]);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    logic [18:0] got;
    n0 = dv_cnt[0];
    send_frame(0, 9'h0AB, 1'b0, 2'b11, 0);
    got = {8'(dv_cnt[0] - n0), last_byte[0], last_pe[0], last_fe[0]};
    tests++;
    if (got !== {8'd1, 9'h0AB, 2'b00}) begin
      fails++; $display("FAIL b2b_first got=%h exp=%h", got, {8'd1, 9'h0AB, 2'b00});
    end
    send_frame(0, 9'h03F, 1'b0, 2'b11, 0);
    got = {8'(dv_cnt[0] - n0), last_byte[0], last_pe[0], last_fe[0]};
    tests++;
    if (got !== {8'd2, 9'h03F, 2'b00}) begin
      fails++; $display("FAIL b2b_second got=%h exp=%h", got, {8'd2, 9'h03F, 2'b00});
    end
    tests++;
    if (last_gap < 1 || last_gap > 87) begin
      fails++; $display("FAIL b2b_idle_gap got=%0d exp=1..87", last_gap);
    end
  endtask

  task automatic test_parity;
    int n0;
    logic [18:0] got;
    n0 = dv_cnt[1];
    send_frame(1, 9'h03F, 1'b0, 2'b11, 1);
    got = {8'(dv_cnt[1] - n0), last_byte[1], last_pe[1], last_fe[1]};
    tests++;
    if (got !== {8'd1, 9'h03F, 2'b00}) begin
      fails++; $display("FAIL parity_good got=%h exp=%h", got, {8'd1, 9'h03F, 2'b00});
    end
    send_frame(1, 9'h03F, 1'b1, 2'b11, 1);
    got = {8'(dv_cnt[1] - n0), last_byte[1], last_pe[1], last_fe[1]};
    tests++;
    if (got !== {8'd2, 9'h03F, 2'b10}) begin
      fails++; $display("FAIL parity_bad got=%h exp=%h", got, {8'd2, 9'h03F, 2'b10});
    end
  endtask

  task automatic test_glitch;
    int n0;
    logic [18:0] got;
    n0 = dv_cnt[0];
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (20) @(negedge clk);
    rx[0] = 1'b1;
    repeat (150) @(negedge clk);
    tests++;
    if ({dv_cnt[0] - n0, busy0} !== {32'd0, 1'b0}) begin
      fails++; $display("FAIL glitch_reject got_dv=%0d got_busy=%b exp=0/0", dv_cnt[0] - n0, busy0);
    end
    send_frame(0, 9'h055, 1'b0, 2'b11, 1);
    got = {8'(dv_cnt[0] - n0), last_byte[0], last_pe[0], last_fe[0]};
    tests++;
    if (got !== {8'd1, 9'h055, 2'b00}) begin
      fails++; $display("FAIL glitch_then_55 got=%h exp=%h", got, {8'd1, 9'h055, 2'b00});
    end
  endtask

  task automatic test_break;
    int n0;
    logic [18:0] got;
    n0 = dv_cnt[0];
    send_frame(0, 9'h0A5, 1'b0, 2'b00, 0);
    got = {8'(dv_cnt[0] - n0), last_byte[0], last_pe[0], last_fe[0]};
    tests++;
    if (got !== {8'd1, 9'h0A5, 2'b01}) begin
      fails++; $display("FAIL break_a5_frame got=%h exp=%h", got, {8'd1, 9'h0A5, 2'b01});
    end
    drive_bit(0, 1'b1, 87);
    n0 = dv_cnt[0];
    for (int i = 0; i < 20; i++) drive_bit(0, 1'b0, 87);
    got = {8'(dv_cnt[0] - n0), last_byte[0], last_pe[0], last_fe[0]};
    tests++;
    if (got !== {8'd1, 9'h000, 2'b01}) begin
      fails++; $display("FAIL break_held_low got=%h exp=%h", got, {8'd1, 9'h000, 2'b01});
    end
    drive_bit(0, 1'b1, 87);
    drive_bit(0, 1'b1, 87);
    tests++;
    if (busy0 !== 1'b0) begin
      fails++; $display("FAIL break_release_idle got=%b exp=0", busy0);
    end
    send_frame(0, 9'h05A, 1'b0, 2'b11, 1);
    got = {8'(dv_cnt[0] - n0), last_byte[0], last_pe[0], last_fe[0]};
    tests++;
    if (got !== {8'd2, 9'h05A, 2'b00}) begin
      fails++; $display("FAIL break_then_5a got=%h exp=%h", got, {8'd2, 9'h05A, 2'b00});
    end
  endtask

  task automatic test_7o2;
    int n0;
    logic [18:0] got;
    n0 = dv_cnt[2];
    send_frame(2, 9'h041, 1'b1, 2'b11, 1);
    got = {8'(dv_cnt[2] - n0), last_byte[2], last_pe[2], last_fe[2]};
    tests++;
    if (got !== {8'd1, 9'h041, 2'b00}) begin
      fails++; $display("FAIL 7o2_clean got=%h exp=%h", got, {8'd1, 9'h041, 2'b00});
    end
    send_frame(2, 9'h041, 1'b1, 2'b01, 1);
    got = {8'(dv_cnt[2] - n0), last_byte[2], last_pe[2], last_fe[2]};
    tests++;
    if (got !== {8'd2, 9'h041, 2'b01}) begin
      fails++; $display("FAIL 7o2_stop2_low got=%h exp=%h", got, {8'd2, 9'h041, 2'b01});
    end
  endtask

  task automatic test_reset_mid_frame;
    int n0;
    logic [18:0] got;
    logic [8:0] d;
    d = 9'h0C3;
    n0 = dv_cnt[0];
    drive_bit(0, 1'b0, 87);
    for (int i = 0; i < 3; i++) drive_bit(0, d[i], 87);
    drive_bit(0, d[3], 40);
    rst = 1'b1;
    #1;
    tests++;
    if ({dv0, byte0, pe0, fe0, busy0} !== 12'h000) begin
      fails++; $display("FAIL reset_mid_outs got=%h exp=000", {dv0, byte0, pe0, fe0, busy0});
    end
    repeat (3) @(negedge clk);
    rx[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    tests++;
    if (dv_cnt[0] != n0) begin
      fails++; $display("FAIL reset_mid_no_dv got=%0d exp=%0d", dv_cnt[0], n0);
    end
    send_frame(0, d, 1'b0, 2'b11, 1);
    got = {8'(dv_cnt[0] - n0), last_byte[0], last_pe[0], last_fe[0]};
    tests++;
    if (got !== {8'd1, 9'h0C3, 2'b00}) begin
      fails++; $display("FAIL reset_mid_c3 got=%h exp=%h", got, {8'd1, 9'h0C3, 2'b00});
    end
  endtask

  // Random frames with random parity bits and occasional bad stop bits.
  task automatic test_random;
    int n0, nb, pm, ns;
    logic [8:0] d, mask;
    logic pbit, epe, efe;
    logic [1:0] stops;
    logic [18:0] got, exp;
    for (int k = 0; k < 3; k++) begin
      nb = nbits_of(k); pm = pmode_of(k); ns = nstop_of(k);
      mask = 9'((1 << nb) - 1);
      for (int f = 0; f < 8; f++) begin
        d = 9'($urandom) & mask;
        pbit = 1'($urandom);
        stops[0] = ($urandom_range(0, 3) != 0);
        stops[1] = ($urandom_range(0, 3) != 0);
        epe = (pm != 0) && (pbit != ref_par(d, nb, pm));
        efe = 1'b0;
        for (int s = 0; s < ns; s++) if (!stops[s]) efe = 1'b1;
        n0 = dv_cnt[k];
        send_frame(k, d, pbit, stops, 1);
        got = {8'(dv_cnt[k] - n0), last_byte[k], last_pe[k], last_fe[k]};
        exp = {8'd1, d, epe, efe};
        tests++;
        if (got !== exp) begin
          fails++; $display("FAIL random_u%0d_f%0d got=%h exp=%h", k, f, got, exp);
        end
      end
    end
  endtask

  task automatic test_flags_only_with_dv;
    tests++;
    if (stray != 0) begin
      fails++; $display("FAIL flags_without_dv got=%0d exp=0", stray);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 3'b111;
    test_reset();
    test_back_to_back();
    test_parity();
    test_glitch();
    test_break();
    test_7o2();
    test_reset_mid_frame();
    test_random();
    test_flags_only_with_dv();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
